// File: rtl/d7s_scan_ctrl.sv
// d7s_scan_ctrl: 3-digit multiplexed 7-segment scan controller
// with a valid/ready load port and a serial binary-to-BCD converter.
module d7s_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter bit LZB          = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [9:0] load_data,
  output logic       load_ready,
  output logic [2:0] transistor,
  output logic [6:0] d7sp
);

  localparam int CMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SHOW_END  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);

  typedef enum logic { C_IDLE, C_CONV } cst_e;
  typedef enum logic { S_SHOW, S_BLANK } sst_e;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // {transistor, d7sp} for slot s given the committed BCD value
  function automatic logic [9:0] slot_pat(input logic [1:0] s,
                                          input logic [11:0] b);
    logic       hz;
    logic       tz;
    logic       blank;
    logic [3:0] dig;
    hz    = (b[11:8] == 4'd0);
    tz    = (b[7:4] == 4'd0);
    blank = 1'b0;
    dig   = 4'd0;
    case (s)
      2'd0: dig = b[3:0];
      2'd1: begin
        dig   = b[7:4];
        blank = LZB && hz && tz;
      end
      2'd2: begin
        dig   = b[11:8];
        blank = LZB && hz;
      end
      default: blank = 1'b1;
    endcase
    if (blank) return 10'd0;
    return {3'b001 << s, seg7(dig)};
  endfunction

  // ---------------- converter ----------------
  cst_e        cst_q, cst_d;
  logic [9:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  it_q, it_d;
  logic [11:0] disp_q, disp_d;
  logic [11:0] adj;
  logic [11:0] bcd_nx;
  logic        unused_msb;

  assign load_ready = (cst_q == C_IDLE);
  assign unused_msb = adj[11];

  // converter next state: one shift/add-3 step per CONV cycle
  always_comb begin
    cst_d  = cst_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    it_d   = it_q;
    disp_d = disp_q;
    adj    = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    bcd_nx = {adj[10:0], bin_q[9]};
    case (cst_q)
      C_IDLE: begin
        if (load_valid) begin
          cst_d = C_CONV;
          bin_d = (load_data > 10'd999) ? 10'd999 : load_data;
          bcd_d = '0;
          it_d  = '0;
        end
      end
      C_CONV: begin
        bcd_d = bcd_nx;
        bin_d = {bin_q[8:0], 1'b0};
        it_d  = it_q + 4'd1;
        if (it_q == 4'd9) begin
          disp_d = bcd_nx;
          cst_d  = C_IDLE;
        end
      end
      default: cst_d = C_IDLE;
    endcase
  end

  // converter state and committed display register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cst_q  <= C_IDLE;
      bin_q  <= '0;
      bcd_q  <= '0;
      it_q   <= '0;
      disp_q <= '0;
    end else begin
      cst_q  <= cst_d;
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      it_q   <= it_d;
      disp_q <= disp_d;
    end
  end

  // ---------------- scanner ----------------
  sst_e          sst_q, sst_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          arm_q, arm_d;
  logic [2:0]    tr_q, tr_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    nidx;
  logic [1:0]    lidx;
  logic          load;

  assign transistor = tr_q;
  assign d7sp       = seg_q;

  // scan next state; slot pattern latched only when a SHOW slot opens
  always_comb begin
    sst_d = sst_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    arm_d = 1'b0;
    tr_d  = tr_q;
    seg_d = seg_q;
    load  = 1'b0;
    lidx  = idx_q;
    nidx  = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    if (arm_q) begin
      load  = 1'b1;
      cnt_d = '0;
    end else begin
      case (sst_q)
        S_SHOW: begin
          if (cnt_q == SHOW_END) begin
            cnt_d = '0;
            idx_d = nidx;
            if (BLANK_CYCLES == 0) begin
              load = 1'b1;
              lidx = nidx;
            end else begin
              sst_d = S_BLANK;
              tr_d  = '0;
              seg_d = '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_BLANK: begin
          if (cnt_q == BLANK_END) begin
            cnt_d = '0;
            sst_d = S_SHOW;
            load  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: sst_d = S_SHOW;
      endcase
    end
    if (load) {tr_d, seg_d} = slot_pat(lidx, disp_q);
  end

  // scan state and registered pad outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sst_q <= S_SHOW;
      idx_q <= '0;
      cnt_q <= '0;
      arm_q <= 1'b1;
      tr_q  <= '0;
      seg_q <= '0;
    end else begin
      sst_q <= sst_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      arm_q <= arm_d;
      tr_q  <= tr_d;
      seg_q <= seg_d;
    end
  end

endmodule

// File: tb/tb_d7s_scan_ctrl.sv
// tb_d7s_scan_ctrl: scoreboard bench for d7s_scan_ctrl
// dut0: blank=2 lzb=1, dut1: blank=2 lzb=0, dut2: blank=0 lzb=1
module tb_d7s_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lv  = 1'b0;
  logic [9:0] ld  = '0;
  logic       rdy[3];
  logic [2:0] tr[3];
  logic [6:0] sg[3];

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  d7s_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYCLES(2), .LZB(1'b1)) u_dut (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld),
    .load_ready(rdy[0]), .transistor(tr[0]), .d7sp(sg[0]));

  d7s_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYCLES(2), .LZB(1'b0)) u_nlz (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld),
    .load_ready(rdy[1]), .transistor(tr[1]), .d7sp(sg[1]));

  d7s_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYCLES(0), .LZB(1'b1)) u_nbk (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld),
    .load_ready(rdy[2]), .transistor(tr[2]), .d7sp(sg[2]));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] t[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[d];
  endfunction

  function automatic logic [11:0] bcd_of(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit blanked(input int d, input int k,
                                 input logic [11:0] b);
    if (d == 1) return 1'b0;
    if (k == 2) return b[11:8] == 4'd0;
    if (k == 1) return (b[11:8] == 4'd0) && (b[7:4] == 4'd0);
    return 1'b0;
  endfunction

  function automatic logic [6:0] dig_seg(input int k, input logic [11:0] b);
    int v;
    v = (k == 0) ? int'(b[3:0]) : (k == 1) ? int'(b[7:4]) : int'(b[11:8]);
    return seg_of(v);
  endfunction

  // expected {tr,seg} of dut d, c cycles after scan restart
  function automatic logic [9:0] pat(input int d, input int c,
                                     input logic [11:0] b);
    int per;
    int p;
    int slot;
    logic [2:0] one;
    one  = 3'b001;
    per  = (d == 2) ? 4 : 6;
    p    = c % (3 * per);
    slot = p / per;
    if ((p % per) >= 4) return 10'd0;
    if (blanked(d, slot, b)) return 10'd0;
    return {one << slot, dig_seg(slot, b)};
  endfunction

  task automatic timing_run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        check($sformatf("scan_d%0d_c%0d", d, c), {tr[d], sg[d]},
              pat(d, c, 12'h000));
    end
  endtask

  task automatic reset_seq();
    rst = 1'b1;
    lv  = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_out_d%0d", d), {tr[d], sg[d]}, 10'd0);
      check($sformatf("rst_rdy_d%0d", d), rdy[d], 1'b1);
    end
    rst = 1'b0;
    timing_run(36);
  endtask

  task automatic start_load(input int v);
    int n;
    n = 0;
    while (!rdy[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rdy_before_load", rdy[0], 1'b1);
    lv = 1'b1;
    ld = 10'(v);
    @(posedge clk);
    exp_q.push_back((v > 999) ? 999 : v);
  endtask

  task automatic conv_wait(input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    if (!hold) lv = 1'b0;
    while (!rdy[0] && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("conv_busy_cycles", n, 10);
  endtask

  task automatic frame_check();
    int v;
    logic [11:0] b;
    int cnt[3][3];
    int segbad[3];
    int bad[3];
    int k;
    check("sb_nonempty", exp_q.size() > 0, 1);
    v = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    b = bcd_of(v);
    for (int d = 0; d < 3; d++) begin
      segbad[d] = 0;
      bad[d]    = 0;
      for (int j = 0; j < 3; j++) cnt[d][j] = 0;
    end
    repeat (18) @(negedge clk);
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        k = -1;
        case (tr[d])
          3'b000: if (sg[d] != 7'd0) bad[d]++;
          3'b001: k = 0;
          3'b010: k = 1;
          3'b100: k = 2;
          default: bad[d]++;
        endcase
        if (k >= 0) begin
          cnt[d][k]++;
          if (sg[d] != dig_seg(k, b)) segbad[d]++;
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("v%0d_d%0d_bad", v, d), bad[d], 0);
      check($sformatf("v%0d_d%0d_seg", v, d), segbad[d], 0);
      for (int j = 0; j < 3; j++)
        check($sformatf("v%0d_d%0d_k%0d_on", v, d, j), cnt[d][j],
              blanked(d, j, b) ? 0 : ((d == 2) ? 12 : 8));
    end
  endtask

  int vals[8] = '{472, 1023, 5, 0, 100, 40, 999, 7};

  initial begin
    reset_seq();

    foreach (vals[i]) begin
      start_load(vals[i]);
      conv_wait(1'b0);
      frame_check();
    end

    // valid held through CONV: second value taken 11 cycles after first
    start_load(123);
    #1 ld = 10'd456;
    conv_wait(1'b1);
    void'(exp_q.pop_front());
    @(posedge clk);
    exp_q.push_back(456);
    conv_wait(1'b0);
    frame_check();

    // asynchronous reset mid-conversion while a digit is lit
    start_load(888);
    @(negedge clk);
    lv = 1'b0;
    for (int n = 0; n < 8 && tr[1] == 3'b000; n++) @(negedge clk);
    check("mid_conv_busy", rdy[0], 1'b0);
    check("lit_before_rst", tr[1] != 3'b000, 1'b1);
    void'(exp_q.pop_back());
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++)
      check($sformatf("async_off_d%0d", d), {tr[d], sg[d]}, 10'd0);
    reset_seq();

    start_load(61);
    conv_wait(1'b0);
    frame_check();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
